// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus plus console byte stream, shared by the CPU side (master) and the responder (slave).
interface data_mem_responder_if;
    logic [31:0] ALUResult;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output ALUResult, MemWrite, WriteData, tx_ready,
        input  ReadData, tx_valid, tx_data
    );

    modport slave (
        input  ALUResult, MemWrite, WriteData, tx_ready,
        output ReadData, tx_valid, tx_data
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, console TX FIFO, status and cycle-counter MMIO registers.
// Optional DMEM_ADDR_CHECK_EN adds a registered addr_err pulse for misaligned or unmapped stores.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic clk,
    input  logic Reset,
`ifdef DMEM_ADDR_CHECK_EN
    output logic addr_err,
`endif
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0]   RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    logic [31:0]   addr;
    logic          ram_hit;
    logic          mmio_hit;
    logic [1:0]    reg_sel;
    logic [AW-1:0] ram_idx;

    assign addr     = bus.ALUResult;
    assign ram_hit  = (addr < RAM_BYTES);
    assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
    assign reg_sel  = addr[3:2];
    assign ram_idx  = addr[AW+1:2];

    logic [31:0] ram_q [DEPTH_WORDS];

    logic [31:0]   cycles_q, cycles_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];

    logic push_req, clr_req, pop, push_ok, ovf_set;
    logic fifo_empty, fifo_full;
    logic [FIFO_DEPTH-1:0] entry_we;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FIFO_FULL);
        push_req   = bus.MemWrite && mmio_hit && (reg_sel == 2'd0);
        clr_req    = bus.MemWrite && mmio_hit && (reg_sel == 2'd3);
        pop        = !fifo_empty && bus.tx_ready;
        // A push into a full FIFO still lands when the head leaves in the same cycle.
        push_ok    = push_req && (!fifo_full || pop);
        ovf_set    = push_req && fifo_full && !pop;

        wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        ovf_d      = ovf_set || (ovf_q && !clr_req);
        cycles_d   = cycles_q + 32'd1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push_ok && (wr_ptr_q == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (Reset) begin
            cycles_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cycles_q <= cycles_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (entry_we[i]) begin
                    fifo_mem_q[i] <= bus.WriteData[7:0];
                end
            end
        end
    end

    // RAM is deliberately left unreset so it can map onto plain storage.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && ram_hit) begin
            ram_q[ram_idx] <= bus.WriteData;
        end
    end

    logic [31:0] read_data;
    always_comb begin
        read_data = '0;
        if (ram_hit) begin
            read_data = ram_q[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                2'd1:    read_data = {28'b0, ovf_q, fifo_full, fifo_empty, !fifo_empty};
                2'd2:    read_data = cycles_q;
                default: read_data = '0;
            endcase
        end
    end

    assign bus.ReadData = read_data;
    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];

`ifdef DMEM_ADDR_CHECK_EN
    logic addr_err_q, addr_err_d;

    always_comb begin
        addr_err_d = bus.MemWrite && ((addr[1:0] != 2'b00) || (!ram_hit && !mmio_hit));
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;
`else
    logic addr_low_unused;
    assign addr_low_unused = ^addr[1:0];
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, directed FIFO/counter sequences, random traffic vs a queue model.
module tb_data_mem_responder;
    localparam logic [31:0] A_TX = 32'h0000_1000;
    localparam logic [31:0] A_ST = 32'h0000_1004;
    localparam logic [31:0] A_CY = 32'h0000_1008;
    localparam logic [31:0] A_CL = 32'h0000_100C;

    logic clk = 1'b0;
    logic Reset;
    data_mem_responder_if bus();
`ifdef DMEM_ADDR_CHECK_EN
    logic addr_err;
`endif

    data_mem_responder dut (
        .clk      (clk),
        .Reset    (Reset),
`ifdef DMEM_ADDR_CHECK_EN
        .addr_err (addr_err),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain arrays and a byte queue updated at each rising edge.
    logic [31:0] m_ram [64];
    bit          m_known [64];
    logic [7:0]  m_q [$];
    bit          m_ovf;
    logic [31:0] m_cyc;
    bit          m_err;
    logic [31:0] ma;
    bit          m_hit_ram, m_hit_mm, m_push, m_clr, m_pop;

    always @(posedge clk) begin
        ma        = bus.ALUResult;
        m_hit_ram = (ma < 32'd256);
        m_hit_mm  = (ma[31:4] == 28'h0000100);
        if (bus.MemWrite && m_hit_ram) begin
            m_ram[ma[7:2]]   = bus.WriteData;
            m_known[ma[7:2]] = 1'b1;
        end
        m_err = !Reset && bus.MemWrite && ((ma[1:0] != 2'b00) || (!m_hit_ram && !m_hit_mm));
        if (Reset) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cyc = 32'd0;
        end else begin
            m_cyc  = m_cyc + 32'd1;
            m_push = bus.MemWrite && m_hit_mm && (ma[3:2] == 2'd0);
            m_clr  = bus.MemWrite && m_hit_mm && (ma[3:2] == 2'd3);
            m_pop  = (m_q.size() != 0) && bus.tx_ready;
            if (m_clr) m_ovf = 1'b0;
            if (m_push && m_q.size() == 8 && !m_pop) m_ovf = 1'b1;
            if (m_pop) void'(m_q.pop_front());
            if (m_push && m_q.size() < 8) m_q.push_back(bus.WriteData[7:0]);
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a < 32'd256) begin
            known = m_known[a[7:2]];
            return m_ram[a[7:2]];
        end
        if (a[31:4] == 28'h0000100) begin
            case (a[3:2])
                2'd1: return {28'b0, m_ovf, m_q.size() == 8, m_q.size() == 0, m_q.size() != 0};
                2'd2: return m_cyc;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit known;
        logic [31:0] exp_rd;
        exp_rd = model_read(bus.ALUResult, known);
        if (known) check32("model_rd", bus.ReadData, exp_rd);
        check32("model_valid", {31'b0, bus.tx_valid}, {31'b0, m_q.size() != 0});
        check32("model_data", {24'b0, bus.tx_data}, {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
`ifdef DMEM_ADDR_CHECK_EN
        check32("model_addr_err", {31'b0, addr_err}, {31'b0, m_err});
`endif
    endtask

    task automatic drive(input logic [31:0] a, input bit we, input logic [31:0] wd, input bit rdy);
        bus.ALUResult = a;
        bus.MemWrite  = we;
        bus.WriteData = wd;
        bus.tx_ready  = rdy;
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [31:0] a, input bit we, input logic [31:0] wd, input bit rdy);
        drive(a, we, wd, rdy);
        settle();
        tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(32'd0, 1'b0, 32'd0, 1'b0);
        settle();
        tick();
        Reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wd;
        bit          rdy;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_v;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t tbl[18];
    logic [31:0] c1, c2, ra;
    int r;

    initial begin
        tbl[0]  = '{32'h0000_1004, 1'b0, 32'h0,         1'b0, 1'b1, 32'h2,         1'b0, 8'h00};
        tbl[1]  = '{32'h0000_0010, 1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
        tbl[2]  = '{32'h0000_0010, 1'b0, 32'h0,         1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 8'h00};
        tbl[3]  = '{32'h0000_0010, 1'b1, 32'h12345678,  1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 8'h00};
        tbl[4]  = '{32'h0000_0010, 1'b0, 32'h0,         1'b0, 1'b1, 32'h12345678,  1'b0, 8'h00};
        tbl[5]  = '{32'h0000_0013, 1'b0, 32'h0,         1'b0, 1'b1, 32'h12345678,  1'b0, 8'h00};
        tbl[6]  = '{32'h0000_0014, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
        tbl[7]  = '{32'h0000_1000, 1'b1, 32'h00000141,  1'b0, 1'b1, 32'h0,         1'b0, 8'h00};
        tbl[8]  = '{32'h0000_1004, 1'b0, 32'h0,         1'b0, 1'b1, 32'h1,         1'b1, 8'h41};
        tbl[9]  = '{32'h0000_2000, 1'b1, 32'h0000FFFF,  1'b0, 1'b1, 32'h0,         1'b1, 8'h41};
        tbl[10] = '{32'h0000_2000, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 8'h41};
        tbl[11] = '{32'h0000_1000, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 8'h41};
        tbl[12] = '{32'h0000_1004, 1'b0, 32'h0,         1'b0, 1'b1, 32'h2,         1'b0, 8'h00};
        tbl[13] = '{32'h0000_00FC, 1'b1, 32'hA5A5A5A5,  1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
        tbl[14] = '{32'h0000_0100, 1'b1, 32'h5A5A5A5A,  1'b0, 1'b1, 32'h0,         1'b0, 8'h00};
        tbl[15] = '{32'h0000_00FC, 1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5A5A5,  1'b0, 8'h00};
        tbl[16] = '{32'h0000_0100, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'h00};
        tbl[17] = '{32'h0000_100C, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'h00};

        Reset = 1'b1;
        drive(32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        Reset = 1'b0;
        do_reset();

        // Vector table: RAM access, write-then-read ordering, decode edges, single-byte FIFO trip.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].addr, tbl[i].we, tbl[i].wd, tbl[i].rdy);
            settle();
            if (tbl[i].chk_rd) check32($sformatf("vec%0d_rd", i), bus.ReadData, tbl[i].exp_rd);
            check32($sformatf("vec%0d_valid", i), {31'b0, bus.tx_valid}, {31'b0, tbl[i].exp_v});
            check32($sformatf("vec%0d_data", i), {24'b0, bus.tx_data}, {24'b0, tbl[i].exp_d});
            tick();
        end

        // Fill, overflow, ordered drain.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(A_TX, 1'b1, 32'h41 + 32'(i), 1'b0);
        drive(A_ST, 1'b0, 32'd0, 1'b0); settle(); check32("full_status", bus.ReadData, 32'h5); tick();
        cyc(A_TX, 1'b1, 32'h49, 1'b0);
        drive(A_ST, 1'b0, 32'd0, 1'b0); settle(); check32("ovf_status", bus.ReadData, 32'hD); tick();
        for (int i = 0; i < 8; i++) begin
            drive(A_ST, 1'b0, 32'd0, 1'b1); settle();
            check32($sformatf("drain%0d", i), {24'b0, bus.tx_data}, 32'h41 + 32'(i));
            tick();
        end
        drive(A_ST, 1'b0, 32'd0, 1'b0); settle(); check32("drained_status", bus.ReadData, 32'hA); tick();
        cyc(A_CL, 1'b1, 32'd0, 1'b0);
        drive(A_ST, 1'b0, 32'd0, 1'b0); settle(); check32("clr_status", bus.ReadData, 32'h2); tick();

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) cyc(A_TX, 1'b1, 32'h60 + 32'(i), 1'b0);
        drive(A_TX, 1'b1, 32'h55, 1'b1); settle();
        check32("pushpop_head", {24'b0, bus.tx_data}, 32'h60); tick();
        drive(A_ST, 1'b0, 32'd0, 1'b0); settle(); check32("pushpop_status", bus.ReadData, 32'h5); tick();
        for (int i = 0; i < 8; i++) begin
            drive(A_ST, 1'b0, 32'd0, 1'b1); settle();
            check32($sformatf("pp_drain%0d", i), {24'b0, bus.tx_data}, (i == 7) ? 32'h55 : 32'h61 + 32'(i));
            tick();
        end

        // Overflow then CLR while still full.
        for (int i = 0; i < 9; i++) cyc(A_TX, 1'b1, 32'h70 + 32'(i), 1'b0);
        drive(A_ST, 1'b0, 32'd0, 1'b0); settle(); check32("ovf2_status", bus.ReadData, 32'hD); tick();
        cyc(A_CL, 1'b1, 32'd0, 1'b0);
        drive(A_ST, 1'b0, 32'd0, 1'b0); settle(); check32("clr_full_status", bus.ReadData, 32'h5); tick();

        // Cycle counter spacing, then reset mid-drain with a push in the reset cycle.
        drive(A_CY, 1'b0, 32'd0, 1'b0); settle(); c1 = bus.ReadData; tick();
        for (int i = 0; i < 6; i++) cyc(32'd0, 1'b0, 32'd0, 1'b0);
        drive(A_CY, 1'b0, 32'd0, 1'b0); settle(); c2 = bus.ReadData; tick();
        check32("cycles_delta", c2 - c1, 32'd7);
        for (int i = 0; i < 3; i++) cyc(A_ST, 1'b0, 32'd0, 1'b1);
        Reset = 1'b1;
        drive(A_TX, 1'b1, 32'h77, 1'b1); settle(); tick();
        Reset = 1'b0;
        drive(A_CY, 1'b0, 32'd0, 1'b0); settle();
        check32("rst_cycles", bus.ReadData, 32'd0);
        check32("rst_valid", {31'b0, bus.tx_valid}, 32'd0);
        check32("rst_data", {24'b0, bus.tx_data}, 32'd0);
        tick();
        drive(A_ST, 1'b0, 32'd0, 1'b0); settle(); check32("rst_status", bus.ReadData, 32'h2); tick();
        drive(A_CY, 1'b0, 32'd0, 1'b0); settle(); check32("rst_cycles2", bus.ReadData, 32'd2); tick();

`ifdef DMEM_ADDR_CHECK_EN
        cyc(32'h13, 1'b1, 32'h1, 1'b0);
        drive(32'h10, 1'b0, 32'd0, 1'b0); settle(); check32("err_misaligned", {31'b0, addr_err}, 32'd1); tick();
        drive(32'h10, 1'b0, 32'd0, 1'b0); settle(); check32("err_clear", {31'b0, addr_err}, 32'd0); tick();
        cyc(32'h2000, 1'b1, 32'h1, 1'b0);
        drive(32'h10, 1'b0, 32'd0, 1'b0); settle(); check32("err_unmapped", {31'b0, addr_err}, 32'd1); tick();
        cyc(32'h10, 1'b1, 32'h2, 1'b0);
        drive(32'h10, 1'b0, 32'd0, 1'b0); settle(); check32("err_aligned", {31'b0, addr_err}, 32'd0); tick();
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: ra = {24'b0, 6'($urandom), 2'b00};
                3, 4:    ra = A_TX;
                5:       ra = A_ST;
                6:       ra = A_CY;
                7:       ra = A_CL;
                8:       ra = 32'h1010 + 32'($urandom_range(0, 255));
                default: ra = 32'h100 + 32'($urandom_range(0, 4096));
            endcase
            if ($urandom_range(0, 3) == 0) ra[1:0] = 2'($urandom);
            Reset = ($urandom_range(0, 63) == 0);
            cyc(ra, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0);
            Reset = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
